// File: rtl/score_to_digits_pkg.sv
// Shared constants, FSM state type and digit place indices for the score-to-BCD path.
// Place indices are also used by the renderer's place-select logic.
package score_to_digits_pkg;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + BIN_W;
  localparam int CNT_W  = 5;

  localparam logic [BIN_W-1:0] MAX_SCORE = 20'd999999;

  localparam int ONES              = 0;
  localparam int TENS              = 1;
  localparam int HUNDREDS          = 2;
  localparam int THOUSANDS         = 3;
  localparam int TEN_THOUSANDS     = 4;
  localparam int HUNDRED_THOUSANDS = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  typedef logic [3:0] digit_t;

  function automatic logic [BIN_W-1:0] clamp_score(input logic [BIN_W-1:0] v);
    return (v > MAX_SCORE) ? MAX_SCORE : v;
  endfunction

endpackage

// File: rtl/score_to_digits_if.sv
// Start/busy/done handshake plus the committed digit buses between game logic and renderer.
// master = score source / renderer side, slave = converter.
interface score_to_digits_if;
  import score_to_digits_pkg::*;

  logic             start;
  logic [BIN_W-1:0] value;
  logic             busy;
  logic             done;
  logic             saturated;
  digit_t           display_ones;
  digit_t           display_tens;
  digit_t           display_hundreds;
  digit_t           display_thousands;
  digit_t           display_ten_thousands;
  digit_t           display_hundred_thousands;

  modport master (
    output start, value,
    input  busy, done, saturated,
    input  display_ones, display_tens, display_hundreds,
    input  display_thousands, display_ten_thousands, display_hundred_thousands
  );

  modport slave (
    input  start, value,
    output busy, done, saturated,
    output display_ones, display_tens, display_hundreds,
    output display_thousands, display_ten_thousands, display_hundred_thousands
  );

endinterface

// File: rtl/score_to_digits_bcd_digit_adj.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
// Purely combinational, no latency, no flow control.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/score_to_digits.sv
// Iterative binary-to-BCD converter for the on-screen score (shift-add-3).
// Latency 21 cycles start-to-done; start is ignored while busy, never queued.
module score_to_digits
  import score_to_digits_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  score_to_digits_if.slave   bus
);

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SR_W-1:0]              sr_q, sr_d;
  logic                         sat_q, sat_d;
  logic [DIGITS-1:0][3:0]       disp_q, disp_d;
  logic                         saturated_q, saturated_d;
  logic                         done_q, done_d;
  logic [BCD_W-1:0]             adj_bcd;

  // All nibbles are corrected in parallel from the pre-shift scratch.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (sr_q[BIN_W + 4*i +: 4]),
      .nib_o (adj_bcd[4*i +: 4])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    sat_d       = sat_q;
    disp_d      = disp_q;
    saturated_d = saturated_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {{BCD_W{1'b0}}, clamp_score(bus.value)};
          sat_d   = (bus.value > MAX_SCORE);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {adj_bcd, sr_q[BIN_W-1:0]} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < DIGITS; i++) disp_d[i] = sr_q[BIN_W + 4*i +: 4];
        saturated_d = sat_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      sat_q       <= 1'b0;
      disp_q      <= '0;
      saturated_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      sat_q       <= sat_d;
      disp_q      <= disp_d;
      saturated_q <= saturated_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy                      = (state_q != IDLE);
  assign bus.done                      = done_q;
  assign bus.saturated                 = saturated_q;
  assign bus.display_ones              = disp_q[ONES];
  assign bus.display_tens              = disp_q[TENS];
  assign bus.display_hundreds          = disp_q[HUNDREDS];
  assign bus.display_thousands         = disp_q[THOUSANDS];
  assign bus.display_ten_thousands     = disp_q[TEN_THOUSANDS];
  assign bus.display_hundred_thousands = disp_q[HUNDRED_THOUSANDS];

endmodule
